// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch unit
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_INC = 32'd4;
  typedef enum logic [1:0] {IDLE, WAIT, DROP} fetch_state_t;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of {pc, instr} entries with clear priority over push and pop
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int W = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    clear,
  input  logic [W-1:0]            wdata,
  output logic [W-1:0]            rdata,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign rdata = mem[rd_ptr];
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk_i)
    if (rst_i || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(push);
      count <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk_i)
    if (push && !clear && !rst_i) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end with req/ack memory port, output buffer, stall and flush
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_ack_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] instruction_o,
  output logic            valid_o
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int NW = CW + 1;
  localparam logic [NW-1:0] DEPTH_N = NW'(BUF_DEPTH);
  fetch_state_t state;
  logic [XLEN-1:0] pc, pc_next;
  logic [CW-1:0] count;
  logic [NW-1:0] next_count;
  logic [2*XLEN-1:0] head;
  logic full, empty, ack, push, pop, more;
  assign ack = imem_req_o && imem_ack_i;
  assign push = state == WAIT && ack && !flush_i;
  assign pop = !empty && !stall_i && !flush_i;
  assign next_count = {1'b0, count} + NW'(push) - NW'(pop);
  assign more = next_count < DEPTH_N;
  assign pc_next = pc + PC_INC;
  assign valid_o = !empty;
  assign pc_o = empty ? '0 : head[2*XLEN-1:XLEN];
  assign instruction_o = empty ? '0 : head[XLEN-1:0];
  fetch_buffer #(.DEPTH(BUF_DEPTH), .W(2*XLEN)) u_buf (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .push(push),
    .pop(pop),
    .clear(flush_i),
    .wdata({pc, imem_rdata_i}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state <= IDLE;
      pc <= RESET_PC;
      imem_req_o <= 1'b0;
      imem_addr_o <= '0;
    end else begin
      case (state)
        IDLE:
          if (flush_i) pc <= redirect_pc_i;
          else if (!full) begin
            imem_req_o <= 1'b1;
            imem_addr_o <= pc;
            state <= WAIT;
          end
        WAIT:
          if (flush_i) begin
            pc <= redirect_pc_i;
            imem_req_o <= !ack;
            state <= ack ? IDLE : DROP;
          end else if (ack) begin
            pc <= pc_next;
            if (more) imem_addr_o <= pc_next;
            else begin
              imem_req_o <= 1'b0;
              state <= IDLE;
            end
          end
        DROP: begin
          if (flush_i) pc <= redirect_pc_i;
          if (ack) begin
            imem_req_o <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a stream-level reference model
module tb_fetch_unit;
  logic clk, rst, stall, flush, imem_req, imem_ack, valid;
  logic [31:0] redirect_pc, imem_addr, imem_rdata, pc, instr;
  int total = 0, passed = 0, pops = 0, p0, wait_cnt = 0, lat = 0, fixed_lat = 0;
  bit rand_lat = 0, stray_ack = 0;
  logic [31:0] exp_pc = 0, last_addr = 0, rp;
  logic last_req = 0, last_rst = 1, last_flush = 0;
  fetch_unit dut (
    .clk_i(clk),
    .rst_i(rst),
    .stall_i(stall),
    .flush_i(flush),
    .redirect_pc_i(redirect_pc),
    .imem_req_o(imem_req),
    .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack),
    .imem_rdata_i(imem_rdata),
    .pc_o(pc),
    .instruction_o(instr),
    .valid_o(valid)
  );
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0001;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else passed++;
  endtask
  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] p);
    @(negedge clk);
    if (last_req && !last_rst && !imem_ack) begin
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, last_addr);
    end
    if (last_flush) check("flush_clears", valid, 0);
    if (!r && valid && !s && !f) begin
      check("pc", pc, exp_pc);
      check("instr", instr, word(exp_pc));
      exp_pc += 4;
      pops++;
    end
    rst = r;
    stall = s;
    flush = f;
    redirect_pc = p;
    if (r) exp_pc = 0;
    else if (f) exp_pc = p;
    last_flush = f && !r;
    last_rst = r;
    last_req = imem_req;
    last_addr = imem_addr;
  endtask
  task automatic do_reset();
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", valid, 0);
    check("rst_pc", pc, 0);
    check("rst_instr", instr, 0);
  endtask
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    imem_ack = 0;
    imem_rdata = 0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_ack || !imem_req) begin
        wait_cnt = 0;
        lat = rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
      end
      imem_ack = (imem_req && wait_cnt >= lat) || stray_ack;
      imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;
      if (imem_req && !imem_ack) wait_cnt++;
    end
  end
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
  initial begin
    rst = 1;
    stall = 0;
    flush = 0;
    redirect_pc = 0;
    fixed_lat = 0;
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      step(0, 0, 0, 0);
      check("zw_addr", imem_addr, 32'(4 * (k - 1)));
      if (k >= 2) check("zw_valid", valid, 1);
    end
    fixed_lat = 3;
    do_reset();
    repeat (15) step(0, 1, 0, 0);
    check("stall_req_off", imem_req, 0);
    check("stall_valid", valid, 1);
    check("stall_head", pc, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("stall_exact2", valid, 0);
    check("resume_req", imem_req, 1);
    check("resume_addr", imem_addr, 8);
    repeat (12) step(0, 0, 0, 0);
    fixed_lat = 2;
    do_reset();
    p0 = pops;
    step(0, 1'b0, 1'b1, 32'h100);
    check("drop_wait_req", imem_req, 1);
    check("drop_wait_addr", imem_addr, 0);
    repeat (4) step(0, 0, 0, 0);
    check("redir_req", imem_req, 1);
    check("redir_addr", imem_addr, 32'h100);
    repeat (10) step(0, 0, 0, 0);
    check("redir_progress", pops > p0, 1);
    fixed_lat = 1;
    do_reset();
    step(0, 0, 0, 0);
    step(0, 0, 1, 32'h200);
    step(0, 0, 0, 0);
    check("fa_req_off", imem_req, 0);
    check("fa_empty", valid, 0);
    step(0, 0, 0, 0);
    check("fa_req", imem_req, 1);
    check("fa_addr", imem_addr, 32'h200);
    repeat (10) step(0, 0, 0, 0);
    fixed_lat = 5;
    do_reset();
    step(0, 0, 0, 0);
    check("rw_req", imem_req, 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    stray_ack = 1;
    check("rw_req_off", imem_req, 0);
    check("rw_valid", valid, 0);
    step(0, 0, 0, 0);
    stray_ack = 0;
    check("rw_req_again", imem_req, 1);
    check("rw_addr", imem_addr, 0);
    repeat (20) step(0, 0, 0, 0);
    fixed_lat = 0;
    do_reset();
    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("wrap_first", imem_addr, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    check("wrap_addr", imem_addr, 0);
    repeat (6) step(0, 0, 0, 0);
    rand_lat = 1;
    do_reset();
    p0 = pops;
    for (int i = 0; i < 2000; i++) begin
      rp = ($urandom % 8 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
      step(($urandom % 300) == 0, ($urandom % 4) == 0, ($urandom % 20) == 0, rp);
    end
    check("rand_progress", (pops - p0) > 100, 1);
    repeat (10) step(0, 0, 0, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
